serial_char_transmit: RTL and testbench
=======================================

// Module: serial_char_transmit
// PURPOSE
//  Transmit half of the chat serial link; counterpart of the character receiver.
//  Takes one parallel character from the keyboard/UI side and serialises it onto the line.
//  Frame: start bit (0), DATA_BITS data bits LSB first, stop bit (1). Line idles high.
//  Every bit is held for CLKS_PER_BIT srClock cycles, matching the receiver's per-bit sampling count.
// PARAMETERS
//  DATA_BITS     8   character width in bits
//  CLKS_PER_BIT  16  srClock cycles per serial bit; legal range 2..255
// PORTS
//  srClock   in   1          single system clock; all state changes on the rising edge
//  rst       in   1          reset, asynchronous, active-low (0 = reset)
//  txLoad    in   1          request to send txData; sampled only while txBusy==0
//  txData    in   DATA_BITS  character to send; captured on the accepting edge
//  txOut     out  1          serial line, registered
//  txBusy    out  1          1 while a frame is in flight
//  charSent  out  1          one-cycle pulse when the stop bit completes
// BEHAVIOUR
//  - Reset (rst==0, asynchronous): txOut=1, txBusy=0, charSent=0, FSM=IDLE, counters=0.
//    Shift register is cleared.
//  - Reset mid-frame aborts the frame at once: line goes high, no charSent pulse.
//  - FSM states: IDLE, START, DATA, STOP.
//    - IDLE -> START on an edge where txLoad==1.
//    - START -> DATA after CLKS_PER_BIT cycles.
//    - DATA -> STOP after DATA_BITS*CLKS_PER_BIT cycles.
//    - STOP -> IDLE after CLKS_PER_BIT cycles.
//  - Accept edge (IDLE, txLoad==1):
//    - txData is latched into the shift register.
//    - After this edge, txOut=0 and txBusy=1. Latency from load to start bit is 1 edge.
//  - Bit timer: counts 0..CLKS_PER_BIT-1 and wraps; its wrap marks the bit boundary.
//    - In DATA, the shift register shifts right at each boundary and txOut = shreg[0].
//    - The bit index counts 0..DATA_BITS-1.
//  - Frame length is exactly (DATA_BITS+2)*CLKS_PER_BIT cycles of txBusy==1.
//  - End of frame: on the edge where the stop bit's last cycle ends:
//    - charSent=1 for exactly that one cycle, txBusy=0, txOut stays 1.
//  - Back-to-back: if txLoad is high in the cycle charSent==1, the next frame is accepted
//    on the following edge. The idle gap between frames is therefore exactly 1 cycle.
//  - txLoad while txBusy==1 is ignored; no queueing.
//    Changes to txData during a frame have no effect on the frame.
//  - txLoad held permanently high sends the same latched value repeatedly,
//    with a 1-cycle idle gap between frames.
//  - txOut, txBusy and charSent are all registered; there are no combinational paths
//    from inputs to outputs.
// STRUCTURE
//  - Shared package / include serial_link_defs:
//    - FSM state encoding: IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3.
//    - Default DATA_BITS and CLKS_PER_BIT, shared with the receiver so both ends agree.
//  - One sub-module, serial_bit_timer:
//    - Parameterised modulo-CLKS_PER_BIT counter with clear input and a 1-cycle wrap tick.
//    - The receiver can reuse it.
//  - Top level holds the FSM, bit index counter and shift register.
// TESTING  (bench uses DATA_BITS=8, CLKS_PER_BIT=4, rst low for 2 cycles)
//  1. After reset, no load for 20 cycles -> txOut=1, txBusy=0, charSent=0 throughout.
//  2. txLoad=1 for one cycle with txData=8'h41
//     -> txOut, 4 cycles each: 0,1,0,0,0,0,0,1,0,1.
//     -> txBusy high for 40 cycles; charSent pulses once, on the 40th edge after accept.
//  3. Mid-frame, txLoad=1 with txData=8'hFF at cycle 10
//     -> ignored; the frame still carries 8'h41 and ends at cycle 40.
//  4. txLoad held high with txData=8'h55 for 3 frames
//     -> frames start 41 cycles apart (1 idle cycle each).
//     -> data bits alternate 1,0,...; 3 charSent pulses.
//  5. rst driven low at cycle 17 of a frame
//     -> txOut=1, txBusy=0 immediately (before the next edge); no charSent.
//     -> The next load after rst is released sends a clean full frame.
//  6. Corner values 8'h00 and 8'hFF
//     -> 8'h00: line low for 36 cycles, then stop high.
//     -> 8'hFF: line low for only the 4-cycle start bit.

Source files
------------

// File: rtl/serial_link_defs_pkg.sv
// Shared serial-link definitions: FSM encoding and default framing parameters
// used by both the transmitter and the receiver so both ends agree.
package serial_link_defs_pkg;

  localparam int unsigned DEFAULT_DATA_BITS    = 8;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } link_state_e;

endpackage : serial_link_defs_pkg

// File: rtl/serial_bit_timer.sv
// Modulo-CLKS_PER_BIT bit timer with synchronous clear; tick_c flags the last
// cycle of each bit period (the wrap).
module serial_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick_c
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  assign tick_c = en && !clr && (cnt_q == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : serial_bit_timer

// File: rtl/serial_char_transmit.sv
// Serial character transmitter: start bit, DATA_BITS data bits LSB first,
// stop bit; line idles high. All outputs registered.
module serial_char_transmit
  import serial_link_defs_pkg::*;
#(
  parameter int unsigned DATA_BITS    = DEFAULT_DATA_BITS,
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                 srClock,
  input  logic                 rst,
  input  logic                 txLoad,
  input  logic [DATA_BITS-1:0] txData,
  output logic                 txOut,
  output logic                 txBusy,
  output logic                 charSent
);

  localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  link_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic                 tx_out_q, tx_out_d;
  logic                 busy_q, busy_d;
  logic                 sent_q, sent_d;
  logic                 tick_c;
  logic                 timer_clr_c;
  logic                 timer_en_c;

  // Timer is held at zero while idle so each frame starts on a fresh bit period.
  assign timer_clr_c = (state_q == ST_IDLE);
  assign timer_en_c  = (state_q != ST_IDLE);

  serial_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (srClock),
    .rst_n  (rst),
    .clr    (timer_clr_c),
    .en     (timer_en_c),
    .tick_c (tick_c)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_idx_d = bit_idx_q;
    tx_out_d  = tx_out_q;
    busy_d    = busy_q;
    sent_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (txLoad) begin
          state_d   = ST_START;
          shreg_d   = txData;
          bit_idx_d = '0;
          tx_out_d  = 1'b0;
          busy_d    = 1'b1;
        end
      end
      ST_START: begin
        if (tick_c) begin
          state_d   = ST_DATA;
          tx_out_d  = shreg_q[0];
          shreg_d   = shreg_q >> 1;
          bit_idx_d = '0;
        end
      end
      // bit_idx_q names the data bit currently on the line.
      ST_DATA: begin
        if (tick_c) begin
          if (bit_idx_q == IDX_LAST) begin
            state_d  = ST_STOP;
            tx_out_d = 1'b1;
          end else begin
            tx_out_d  = shreg_q[0];
            shreg_d   = shreg_q >> 1;
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
      end
      ST_STOP: begin
        if (tick_c) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          sent_d  = 1'b1;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        tx_out_d = 1'b1;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge srClock or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_idx_q <= '0;
      tx_out_q  <= 1'b1;
      busy_q    <= 1'b0;
      sent_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_idx_q <= bit_idx_d;
      tx_out_q  <= tx_out_d;
      busy_q    <= busy_d;
      sent_q    <= sent_d;
    end
  end

  assign txOut    = tx_out_q;
  assign txBusy   = busy_q;
  assign charSent = sent_q;

endmodule : serial_char_transmit

// File: tb/tb_serial_char_transmit.sv
// Directed self-checking bench for serial_char_transmit (DATA_BITS=8, CLKS_PER_BIT=4).
module tb_serial_char_transmit;

  localparam int unsigned DATA_BITS    = 8;
  localparam int unsigned CLKS_PER_BIT = 4;
  localparam int          FRAME_CYC    = (DATA_BITS + 2) * CLKS_PER_BIT;

  logic                 srClock;
  logic                 rst;
  logic                 txLoad;
  logic [DATA_BITS-1:0] txData;
  logic                 txOut;
  logic                 txBusy;
  logic                 charSent;

  int checks = 0;
  int errors = 0;

  serial_char_transmit #(
    .DATA_BITS   (DATA_BITS),
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) dut (
    .srClock (srClock),
    .rst     (rst),
    .txLoad  (txLoad),
    .txData  (txData),
    .txOut   (txOut),
    .txBusy  (txBusy),
    .charSent(charSent)
  );

  initial srClock = 1'b0;
  always #5 srClock = ~srClock;

  // Expected line level k cycles after the accept edge (0 <= k < FRAME_CYC).
  function automatic logic frame_bit(input logic [DATA_BITS-1:0] d, input int k);
    int b;
    b = k / CLKS_PER_BIT;
    if (b == 0) return 1'b0;
    if (b > DATA_BITS) return 1'b1;
    return d[b-1];
  endfunction

  task automatic test_reset();
    rst = 1'b0; txLoad = 1'b0; txData = '0;
    repeat (2) @(negedge srClock);
    checks++;
    if (txOut !== 1'b1 || txBusy !== 1'b0 || charSent !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold out=%b busy=%b sent=%b want 1 0 0", txOut, txBusy, charSent);
    end
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge srClock);
      checks++;
      if (txOut !== 1'b1 || txBusy !== 1'b0 || charSent !== 1'b0) begin
        errors++;
        $display("FAIL idle c=%0d out=%b busy=%b sent=%b want 1 0 0", i, txOut, txBusy, charSent);
      end
    end
  endtask

  // Frame of 8'h41 with an 8'hFF load attempted at cycle 10 when mid_load is set.
  task automatic test_frame(input logic [DATA_BITS-1:0] d, input bit mid_load, input string name);
    int pulses;
    pulses = 0;
    txLoad = 1'b1; txData = d;
    for (int k = 0; k <= FRAME_CYC; k++) begin
      @(negedge srClock);
      checks++;
      if (txOut !== ((k == FRAME_CYC) ? 1'b1 : frame_bit(d, k))) begin
        errors++;
        $display("FAIL %s_out k=%0d got %b", name, k, txOut);
      end
      checks++;
      if (txBusy !== (k < FRAME_CYC)) begin
        errors++;
        $display("FAIL %s_busy k=%0d got %b want %b", name, k, txBusy, k < FRAME_CYC);
      end
      if (charSent === 1'b1) pulses++;
      if (k == 0) txLoad = 1'b0;
      if (mid_load && k == 10) begin txLoad = 1'b1; txData = 8'hFF; end
      if (mid_load && k == 11) txLoad = 1'b0;
    end
    checks++;
    if (pulses != 1 || charSent !== 1'b1) begin
      errors++;
      $display("FAIL %s_sent pulses=%0d last=%b want 1 1", name, pulses, charSent);
    end
    @(negedge srClock);
    checks++;
    if (txBusy !== 1'b0 || charSent !== 1'b0 || txOut !== 1'b1) begin
      errors++;
      $display("FAIL %s_after busy=%b sent=%b out=%b want 0 0 1", name, txBusy, charSent, txOut);
    end
  endtask

  task automatic test_back_to_back();
    int pulses;
    pulses = 0;
    txLoad = 1'b1; txData = 8'h55;
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k <= FRAME_CYC; k++) begin
        @(negedge srClock);
        checks++;
        if (txOut !== ((k == FRAME_CYC) ? 1'b1 : frame_bit(8'h55, k)) ||
            txBusy !== (k < FRAME_CYC) || charSent !== (k == FRAME_CYC)) begin
          errors++;
          $display("FAIL b2b f=%0d k=%0d out=%b busy=%b sent=%b", f, k, txOut, txBusy, charSent);
        end
        if (charSent === 1'b1) pulses++;
        if (f == 2 && k == FRAME_CYC) txLoad = 1'b0;
      end
    end
    checks++;
    if (pulses != 3) begin
      errors++;
      $display("FAIL b2b_pulses got %0d want 3", pulses);
    end
    @(negedge srClock);
    checks++;
    if (txBusy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_stop busy=%b want 0", txBusy);
    end
  endtask

  task automatic test_reset_mid_frame();
    txLoad = 1'b1; txData = 8'h41;
    for (int k = 0; k <= 17; k++) begin
      @(negedge srClock);
      if (k == 0) txLoad = 1'b0;
    end
    checks++;
    if (txBusy !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre busy=%b want 1", txBusy);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (txOut !== 1'b1 || txBusy !== 1'b0 || charSent !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async out=%b busy=%b sent=%b want 1 0 0", txOut, txBusy, charSent);
    end
    repeat (2) @(negedge srClock);
    rst = 1'b1;
    for (int i = 0; i < 45; i++) begin
      @(negedge srClock);
      checks++;
      if (txOut !== 1'b1 || txBusy !== 1'b0 || charSent !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_idle c=%0d out=%b busy=%b sent=%b", i, txOut, txBusy, charSent);
      end
    end
  endtask

  task automatic test_corners(input logic [DATA_BITS-1:0] d, input int want_low);
    int lows;
    lows = 0;
    txLoad = 1'b1; txData = d;
    for (int k = 0; k <= FRAME_CYC; k++) begin
      @(negedge srClock);
      if (txOut === 1'b0) lows++;
      checks++;
      if (txOut !== ((k == FRAME_CYC) ? 1'b1 : frame_bit(d, k))) begin
        errors++;
        $display("FAIL corner_%02h k=%0d out=%b", d, k, txOut);
      end
      if (k == 0) txLoad = 1'b0;
    end
    checks++;
    if (lows != want_low) begin
      errors++;
      $display("FAIL corner_%02h_low got %0d want %0d", d, lows, want_low);
    end
    @(negedge srClock);
  endtask

  initial begin
    test_reset();
    test_frame(8'h41, 1'b0, "frame41");
    test_frame(8'h41, 1'b1, "midload");
    test_back_to_back();
    test_reset_mid_frame();
    test_frame(8'hA5, 1'b0, "postrst");
    test_corners(8'h00, 36);
    test_corners(8'hFF, 4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_serial_char_transmit
